gsensor_tilt_hex_encoder: RTL

GSENSOR_TILT_HEX_ENCODER -- requirements
Module: gsensor_tilt_hex_encoder

---
 rtl/gsensor_hex_pkg.sv | 13 +
 rtl/gsensor_tilt_channel.sv | 89 ++++++++
 rtl/gsensor_tilt_hex_encoder.sv | 42 ++++
 3 files changed

// File: rtl/gsensor_hex_pkg.sv
// Display-code constants shared by the tilt encoder and its per-channel slice.
package gsensor_hex_pkg;
    localparam int CODE_W = 8;
    localparam int MAG_W  = 4;
    localparam logic [CODE_W-1:0] ZERO_CODE  = 8'h00;
    localparam logic [3:0]        NEG_PREFIX = 4'hB;
    localparam logic [3:0]        POS_PREFIX = 4'hA;

    // Zero code has a zero low nibble, so it naturally reads as magnitude 0.
    function automatic logic [MAG_W-1:0] code_mag(input logic [CODE_W-1:0] code);
        return code[MAG_W-1:0];
    endfunction
endpackage

// File: rtl/gsensor_tilt_channel.sv
// One tilt channel: LED-bar decode, stability filter and peak-hold output register.
module gsensor_tilt_channel
    import gsensor_hex_pkg::*;
#(
    parameter int LED_W         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LED_W-1:0]  led,
    input  logic              peak_mode,
    input  logic              peak_clear,
    output logic [CODE_W-1:0] hex,
    output logic              invalid,
    output logic              changed
);
    localparam int H = LED_W / 2;
    localparam logic [7:0]       SAT       = 8'(STABLE_CYCLES);
    localparam logic [LED_W-1:0] CENTRE_HI = LED_W'(1) << H;
    localparam logic [LED_W-1:0] CENTRE_LO = LED_W'(1) << (H - 1);

    logic              valid;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] cand_q, cand_next;
    logic [7:0]        cnt_q, cnt_next;
    logic [CODE_W-1:0] hex_q, hex_next;

    always_comb begin
        valid = 1'b0;
        code  = ZERO_CODE;
        if (led == CENTRE_HI || led == CENTRE_LO || led == (CENTRE_HI | CENTRE_LO)) begin
            valid = 1'b1;
        end else if ($onehot(led)) begin
            valid = 1'b1;
            for (int unsigned p = 0; p < LED_W; p++) begin
                if (led[p]) begin
                    if (p > H)
                        code = {NEG_PREFIX, MAG_W'(p - H)};
                    else
                        code = {POS_PREFIX, MAG_W'(H - 1 - p)};
                end
            end
        end
    end

    always_comb begin
        cand_next = cand_q;
        cnt_next  = cnt_q;
        hex_next  = hex_q;
        if (peak_clear) begin
            cand_next = ZERO_CODE;
            cnt_next  = '0;
            hex_next  = ZERO_CODE;
        end else if (!valid) begin
            cnt_next = '0;
        end else begin
            if (code == cand_q) begin
                cnt_next = (cnt_q >= SAT) ? SAT : cnt_q + 8'd1;
            end else begin
                cand_next = code;
                cnt_next  = 8'd1;
            end
            // Acceptance repeats while the count sits saturated; rewriting the same code is a no-op.
            if (cnt_next == SAT) begin
                if (!peak_mode)
                    hex_next = cand_next;
                else if (code_mag(cand_next) > code_mag(hex_q))
                    hex_next = cand_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q  <= ZERO_CODE;
            cnt_q   <= '0;
            hex_q   <= ZERO_CODE;
            invalid <= 1'b0;
        end else begin
            cand_q  <= cand_next;
            cnt_q   <= cnt_next;
            hex_q   <= hex_next;
            invalid <= ~valid;
        end
    end

    assign hex     = hex_q;
    assign changed = (hex_next != hex_q);
endmodule

// File: rtl/gsensor_tilt_hex_encoder.sv
// Multi-channel accelerometer LED-bar to hex display-code encoder with shared update pulse.
module gsensor_tilt_hex_encoder
    import gsensor_hex_pkg::*;
#(
    parameter int LED_W         = 8,
    parameter int NUM_CH        = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*LED_W-1:0]    led_data,
    input  logic                       peak_mode,
    input  logic                       peak_clear,
    output logic [NUM_CH*CODE_W-1:0]   hex_data,
    output logic                       hex_update,
    output logic [NUM_CH-1:0]          invalid
);
    logic [NUM_CH-1:0] ch_changed;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        gsensor_tilt_channel #(
            .LED_W         (LED_W),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .led        (led_data[c*LED_W +: LED_W]),
            .peak_mode  (peak_mode),
            .peak_clear (peak_clear),
            .hex        (hex_data[c*CODE_W +: CODE_W]),
            .invalid    (invalid[c]),
            .changed    (ch_changed[c])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)
            hex_update <= 1'b0;
        else
            hex_update <= |ch_changed;
    end
endmodule
